// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues word reads at the register-file PC over a
// req/ack port, queues accepted words for decode, and handles flush and halt.
module ifetch_unit #(
  parameter int depthlog = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_incr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        flush,
  input  logic        halt,
  output logic        busy
);

  localparam int DEPTH = 1 << depthlog;
  localparam int PW    = depthlog;
  localparam int CW    = depthlog + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_mem_req;
  logic          w_mem_req_nx;
  logic [31:0]   r_mem_addr;
  logic [31:0]   w_mem_addr_nx;
  logic          w_issue;
  logic          w_pc_incr;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_data [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];

  // Count MSB is set only when the queue holds exactly DEPTH words.
  assign w_issue = !halt && !flush && !r_count[CW-1];
  assign w_pop   = (r_count != {CW{1'b0}}) && instr_ready && !flush;
  assign w_push  = w_pc_incr;

  // Fetch FSM next-state, request and PC-increment decode.
  always_comb begin
    w_state_nx    = r_state;
    w_mem_req_nx  = r_mem_req;
    w_mem_addr_nx = r_mem_addr;
    w_pc_incr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nx    = S_WAIT;
          w_mem_req_nx  = 1'b1;
          w_mem_addr_nx = pc_in;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_state_nx   = S_IDLE;
          w_mem_req_nx = 1'b0;
          w_pc_incr    = !flush;
        end else if (flush) begin
          w_state_nx = S_DISCARD;
        end else begin
          w_state_nx = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (mem_ack) begin
          w_state_nx   = S_IDLE;
          w_mem_req_nx = 1'b0;
        end else begin
          w_state_nx = S_DISCARD;
        end
      end
      default: begin
        w_state_nx   = S_IDLE;
        w_mem_req_nx = 1'b0;
      end
    endcase
  end

  // FSM state and registered memory request/address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'd0;
    end else begin
      r_state    <= w_state_nx;
      r_mem_req  <= w_mem_req_nx;
      r_mem_addr <= w_mem_addr_nx;
    end
  end

  // Instruction queue; flush clears it and overrides any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= 32'd0;
        r_q_pc[i]   <= 32'd0;
      end
    end else if (flush) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_q_data[r_wptr] <= mem_rdata;
        r_q_pc[r_wptr]   <= r_mem_addr;
        r_wptr           <= r_wptr + PW'(1'b1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1'b1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign pc_incr     = w_pc_incr;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = (r_count != {CW{1'b0}});
  assign instr_out   = r_q_data[r_rptr];
  assign instr_pc    = r_q_pc[r_rptr];
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the register file, memory and queue.
module tb_ifetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_incr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        flush;
  logic        halt;
  logic        busy;

  ifetch_unit #(.depthlog(1)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_incr(pc_incr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .flush(flush),
    .halt(halt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  int errors = 0;
  int checks = 0;

  // Model: register-file PC, outstanding fetch (address, doomed flag, age), queue contents.
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_discard;
  int          m_wait_cnt;
  int          ack_lat;
  bit          rand_mode;
  logic [31:0] flush_pc;
  int          incr_seen;
  int          base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req      = 1'b0;
    m_discard  = 1'b0;
    m_addr     = 32'd0;
    m_wait_cnt = 0;
  endtask

  // One clock: drive memory response, check outputs at negedge, advance model at posedge.
  task automatic tick();
    bit   exp_incr;
    bit   pop;
    int   sz;
    ent_t e;
    mem_ack = m_req && (m_wait_cnt >= ack_lat);
    if (rand_mode) mem_rdata = $urandom;
    @(negedge clk);
    exp_incr = m_req && !m_discard && mem_ack && !flush;
    sz = q.size();
    chk("pc_incr", {31'd0, pc_incr}, {31'd0, exp_incr});
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
    chk("busy", {31'd0, busy}, {31'd0, m_req});
    chk("mem_addr", mem_addr, m_addr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, (sz != 0)});
    if (sz != 0) begin
      chk("instr_out", instr_out, q[0].data);
      chk("instr_pc", instr_pc, q[0].pc);
    end
    pop = (sz != 0) && instr_ready && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (exp_incr) begin
        e.pc = m_addr;
        e.data = mem_rdata;
        q.push_back(e);
      end
    end
    if (exp_incr) incr_seen++;
    if (m_req) begin
      if (mem_ack) begin
        m_req = 1'b0;
        m_discard = 1'b0;
      end else begin
        if (flush) m_discard = 1'b1;
        m_wait_cnt++;
      end
    end else if (!halt && !flush && sz < DEPTH) begin
      m_req = 1'b1;
      m_addr = pc_in;
      m_wait_cnt = 0;
      if (rand_mode) ack_lat = $urandom_range(0, 3);
    end
    if (flush) m_pc = flush_pc;
    else if (exp_incr) m_pc = m_pc + 32'd1;
    @(posedge clk);
    #1;
    pc_in = m_pc;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0; instr_ready = 1'b0;
    flush = 1'b0; halt = 1'b0; flush_pc = 32'd0; rand_mode = 1'b0;
    ack_lat = 0; incr_seen = 0; m_pc = 32'h10; pc_in = m_pc;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pc_incr", {31'd0, pc_incr}, 32'd0);
    rst = 1'b0;

    // Reset then fetch: ack in the first WAIT cycle
    mem_rdata = 32'hA000_0001;
    tick();
    chk("fetch_addr", mem_addr, 32'h10);
    tick();
    chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("fetch_out", instr_out, 32'hA000_0001);
    chk("fetch_pc", instr_pc, 32'h10);
    chk("fetch_incr_cnt", incr_seen, 32'd1);

    // Queue full: no pops, exactly two fetches land
    mem_rdata = 32'hA000_0002;
    repeat (6) tick();
    chk("full_incr_cnt", incr_seen, 32'd2);
    chk("full_no_req", {31'd0, mem_req}, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    chk("refill_req", {31'd0, mem_req}, 32'd1);
    chk("refill_addr", mem_addr, 32'h12);
    tick();

    // Flush while waiting: ack arrives 3 cycles after the flush
    flush = 1'b1; flush_pc = 32'h20;
    tick();
    flush = 1'b0; ack_lat = 3;
    tick();
    flush = 1'b1; flush_pc = 32'h30;
    base = incr_seen;
    tick();
    flush = 1'b0; halt = 1'b1;
    chk("discard_req", {31'd0, mem_req}, 32'd1);
    repeat (5) tick();
    chk("discard_no_incr", incr_seen, base);
    chk("discard_empty", {31'd0, instr_valid}, 32'd0);
    chk("discard_idle", {31'd0, busy}, 32'd0);

    // Flush coincident with ack
    halt = 1'b0; ack_lat = 1;
    tick();
    tick();
    flush = 1'b1; flush_pc = 32'h40;
    tick();
    flush = 1'b0;
    chk("flush_ack_no_incr", incr_seen, base);
    tick();
    chk("refetch_addr", mem_addr, 32'h40);
    chk("refetch_req", {31'd0, mem_req}, 32'd1);

    // Halt during WAIT: fetch completes, then no more requests
    halt = 1'b1;
    repeat (4) tick();
    chk("halt_incr", incr_seen, base + 1);
    chk("halt_no_req", {31'd0, mem_req}, 32'd0);
    chk("halt_head_pc", instr_pc, 32'h40);

    // Push and pop in the same cycle at count=1, across pointer wrap
    halt = 1'b0; ack_lat = 0;
    for (int k = 1; k <= 3; k++) begin
      instr_ready = 1'b0;
      tick();
      instr_ready = 1'b1;
      tick();
      chk("pushpop_valid", {31'd0, instr_valid}, 32'd1);
      chk("pushpop_pc", instr_pc, 32'h40 + 32'(k));
    end

    // Reset mid-fetch drops mem_req asynchronously
    instr_ready = 1'b0;
    tick();
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_incr", {31'd0, pc_incr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random traffic
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      halt        = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      instr_ready = $urandom_range(0, 1) == 1;
      flush_pc    = $urandom;
      tick();
    end
    flush = 1'b0; halt = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage that sits directly upstream of the 32-entry register file. It reads the program counter (register 31) from the register file's `pcout` and issues word reads to instruction memory over a req/ack handshake. Each accepted word is pushed into a small instruction queue for the decode stage, and the unit pulses `pcincr` back to the register file. It also handles branch flushes and halts.

## Interface
Parameters:
- `depthlog`, default 1, log2 of queue depth; depth = 2**`depthlog` entries (default 2).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_in`  in  32  current PC, driven from the register file `pcout`.
- `pc_incr`  out  1  combinational; drives the register file `pcincr`.
- `mem_req`  out  1  registered memory read request.
- `mem_addr`  out  32  registered word address; stable while `mem_req` is high.
- `mem_ack`  in  1  single-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  queue is non-empty.
- `instr_out`  out  32  instruction word at the queue head.
- `instr_pc`  out  32  address of the word at the queue head.
- `instr_ready`  in  1  decode accepts the head word this cycle.
- `flush`  in  1  branch or PC write; discards the queue and any in-flight fetch.
- `halt`  in  1  inhibits new fetches.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
FSM states:
- **IDLE**
  - Issue condition: `!halt && !flush && count < depth`.
  - At the edge where the issue condition holds: load `mem_addr <= pc_in`, set `mem_req <= 1`, go to WAIT.
- **WAIT**
  - `mem_ack && !flush`:
    - Push {`mem_addr`, `mem_rdata`} into the queue.
    - `pc_incr` = 1 in this cycle.
    - `mem_req <= 0`; go to IDLE.
  - `mem_ack && flush`: drop the data, `pc_incr` = 0, `mem_req <= 0`, go to IDLE.
  - `!mem_ack && flush`: go to DISCARD; `mem_req` stays 1 and `mem_addr` is unchanged.
  - `!mem_ack && !flush`: hold.
- **DISCARD**
  - `mem_req` stays 1 until `mem_ack`.
  - On `mem_ack`: drop the data, `pc_incr` = 0, `mem_req <= 0`, go to IDLE.
  - `flush` has no further effect in this state.

Rules:
- `pc_incr` = (state == WAIT) && `mem_ack` && !`flush`. It is never asserted in any other case.
- Queue is a circular buffer with read/write pointers and a count of width `depthlog`+1.
  - Pop when `instr_valid && instr_ready && !flush`.
  - Push and pop in the same cycle: both occur and count is unchanged.
  - Pointers wrap modulo depth.
  - The issue condition guarantees that a push never overflows the queue.
- `flush` clears the queue at the edge (count and pointers to 0), overriding any push or pop in that cycle.
- `halt` only blocks the IDLE→WAIT transition. An outstanding fetch completes, pushes, and increments the PC normally. The queue keeps draining while halted.
- Addresses are word addresses, consistent with the register file's +1 PC increment. There are no width conversions.

## Timing
Reset values:
- state = IDLE
- `mem_req` = 0, `mem_addr` = 0
- count and pointers = 0
- `instr_valid` = 0, `instr_out` = 0, `instr_pc` = 0
- `busy` = 0, `pc_incr` = 0

Fetch cycle:
- Cycle n: IDLE with the issue condition true.
- Cycle n+1: WAIT; `mem_req` = 1.
- Earliest ack is cycle n+1.
- At the ack edge the register file increments the PC and the queue pushes. `instr_valid` = 1 from the next cycle.
- The next issue can occur in the IDLE cycle after the ack, which sees the updated `pc_in`.
- Peak throughput is 1 word per 2 cycles.

Reset mid-fetch:
- `mem_req` drops asynchronously.
- The outstanding request is abandoned; memory tolerates this.
- No `pc_incr` is generated.

Flush:
- The flush cycle itself never increments the PC, so the branch write to r31 in the same cycle is not disturbed.
- Re-fetch issues no earlier than the cycle after the flush (or after the DISCARD ack), using the new `pc_in`.

## Test plan
- **Reset then fetch:** `rst` pulse, `pc_in`=0x10, memory acks 1 cycle after req with rdata=0xA0000001.
  - `mem_addr`=0x10.
  - `pc_incr` high exactly in the ack cycle.
  - Next cycle: `instr_valid`=1, `instr_out`=0xA0000001, `instr_pc`=0x10.
- **Queue full:** `instr_ready`=0, `pc_in` follows the increments 0x10→0x12.
  - Exactly 2 fetches complete (0x10, 0x11).
  - `mem_req` stays 0 while count=2.
  - One pop re-enables issue at 0x12.
- **Flush while waiting:** ack delayed 3 cycles, `flush` pulsed in the 1st WAIT cycle.
  - State goes to DISCARD; `mem_req` stays high until ack.
  - Data dropped; `pc_incr` never asserted.
  - `instr_valid`=0.
- **Flush coincident with ack:** word dropped, no `pc_incr`, next fetch uses the new `pc_in`=0x40.
- **Halt and simultaneous push/pop:**
  - `halt` during WAIT: the fetch completes and increments the PC, then no further req.
  - With count=1, push and pop in the same cycle: count stays 1 and `instr_pc` advances correctly across pointer wrap.
